// File: rtl/rr_arb_mux.sv
// rr_arb_mux: round-robin arbitrating, registered N-to-1 multiplexer.
// Each input channel and the output use a valid/ready handshake; the output
// is a single register stage. The winner is searched starting one past the
// most recently granted channel, so every channel that stays valid is served
// within CHANNELS transfers.
// Optional feature: define RR_ARB_MUX_LOCK_EN to add the in_lock burst-lock port.
module rr_arb_mux #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CHANNELS-1:0]           in_valid,
  input  logic [CHANNELS*WIDTH-1:0]     in_data,
  output logic [CHANNELS-1:0]           in_ready,
`ifdef RR_ARB_MUX_LOCK_EN
  input  logic [CHANNELS-1:0]           in_lock,
`endif
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  output logic [$clog2(CHANNELS)-1:0]   out_sel,
  input  logic                          out_ready
);

  localparam int SELW = $clog2(CHANNELS);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [SELW-1:0]   last_q;
  logic [SELW-1:0]   win;
  logic [SELW-1:0]   cand;
  logic              found;
  logic              can_load;
  logic              in_xfer;
  logic [WIDTH-1:0]  win_data;
`ifdef RR_ARB_MUX_LOCK_EN
  logic              locked_q;
`endif

  // Winner search: scan last+CHANNELS down to last+1 so the nearest valid
  // channel after last overrides any farther one.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
`ifdef RR_ARB_MUX_LOCK_EN
    if (locked_q) begin
      // while locked, last_q is the locked channel; nobody else may win
      win   = last_q;
      found = in_valid[last_q];
    end else
`endif
    begin
      for (int unsigned k = CHANNELS; k >= 1; k--) begin
        cand = SELW'((32'(last_q) + k) % 32'(CHANNELS));
        if (in_valid[cand]) begin
          win   = cand;
          found = 1'b1;
        end
      end
    end
  end

  // Handshake: grant is one-hot on the winner when the register can load.
  always_comb begin
    can_load = (state_q == EMPTY) || out_ready;
    in_xfer  = found && can_load && rst_n;
    in_ready = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      in_ready[i] = in_xfer && (win == SELW'(i));
    end
  end

  // Data select for the winning channel.
  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (win == SELW'(i)) begin
        win_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register occupancy: next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (in_xfer) state_d = FULL;
      FULL:    if (out_ready && !in_xfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Output register occupancy: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  assign out_valid = (state_q == FULL);

  // Payload, source index and round-robin pointer load on every input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= '0;
      last_q   <= SELW'(CHANNELS - 1);
    end else if (in_xfer) begin
      out_data <= win_data;
      out_sel  <= win;
      last_q   <= win;
    end
  end

`ifdef RR_ARB_MUX_LOCK_EN
  // Lock follows in_lock of each transferring channel: set on a locked beat,
  // cleared by the locked channel's final unlocked beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       locked_q <= 1'b0;
    else if (in_xfer) locked_q <= in_lock[win];
  end
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed self-checking bench for rr_arb_mux (WIDTH=16, CHANNELS=4).
module tb_rr_arb_mux;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [63:0] in_data;
  logic [3:0]  in_ready;
`ifdef RR_ARB_MUX_LOCK_EN
  logic [3:0]  in_lock;
`endif
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  rr_arb_mux #(.WIDTH(16), .CHANNELS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
`ifdef RR_ARB_MUX_LOCK_EN
    .in_lock   (in_lock),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [15:0] v);
    in_data[ch*16 +: 16] = v;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] sel, input logic [15:0] data);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".sel"},   32'(out_sel),   32'(sel));
    chk({tag, ".data"},  32'(out_data),  32'(data));
  endtask

  initial begin
    // reset with stimulus active
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'b1111;
    in_data   = '0;
`ifdef RR_ARB_MUX_LOCK_EN
    in_lock   = 4'b0000;
`endif
    set_data(0, 16'h1111);
    set_data(1, 16'h2222);
    set_data(2, 16'h3333);
    set_data(3, 16'h4444);
    tick(); tick();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.data",  32'(out_data),  32'd0);
    chk("rst.sel",   32'(out_sel),   32'd0);
    chk("rst.ready", 32'(in_ready),  32'd0);

    // full contention: 0,1,2,3,0
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("cont.ready0", 32'(in_ready), 32'b0001);
    tick(); chk_out("cont0", 2'd0, 16'h1111);
    chk("cont.ready1", 32'(in_ready), 32'b0010);
    tick(); chk_out("cont1", 2'd1, 16'h2222);
    tick(); chk_out("cont2", 2'd2, 16'h3333);
    tick(); chk_out("cont3", 2'd3, 16'h4444);
    tick(); chk_out("cont4", 2'd0, 16'h1111);

    // drain
    in_valid = 4'b0000;
    tick();
    chk("drain.valid", 32'(out_valid), 32'd0);

    // backpressure: channel 2 loads 0xBEEF, out_ready low for 5 cycles
    in_valid  = 4'b0100;
    set_data(2, 16'hBEEF);
    out_ready = 1'b0;
    #1;
    chk("bp.ready_load", 32'(in_ready), 32'b0100);
    tick(); chk_out("bp.load", 2'd2, 16'hBEEF);
    in_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_out("bp.hold", 2'd2, 16'hBEEF);
      chk("bp.ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", 32'(in_ready), 32'b0001);
    tick(); chk_out("bp.next", 2'd0, 16'h1111);

    // wrap: channel 3 transfer sets last=3, then channels 1 and 2
    in_valid = 4'b1000;
    tick(); chk_out("wrap.c3", 2'd3, 16'h4444);
    in_valid = 4'b0110;
    set_data(2, 16'h3333);
    #1;
    chk("wrap.ready", 32'(in_ready), 32'b0010);
    tick(); chk_out("wrap.c1", 2'd1, 16'h2222);
    tick(); chk_out("wrap.c2", 2'd2, 16'h3333);

    // back-to-back on channel 1
    in_valid = 4'b0010;
    for (int b = 0; b < 4; b++) begin
      set_data(1, 16'h5000 + 16'(b));
      tick();
      chk_out("b2b", 2'd1, 16'h5000 + 16'(b));
    end
    in_valid = 4'b0000;
    tick();
    chk("b2b.drain", 32'(out_valid), 32'd0);

    // reset asserted while the register holds data
    in_valid = 4'b1111;
    set_data(1, 16'h2222);
    tick(); chk_out("mid.pre", 2'd2, 16'h3333);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.valid", 32'(out_valid), 32'd0);
    chk("mid.data",  32'(out_data),  32'd0);
    chk("mid.sel",   32'(out_sel),   32'd0);
    chk("mid.ready", 32'(in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid.ready_rel", 32'(in_ready), 32'b0001);
    tick(); chk_out("mid.first", 2'd0, 16'h1111);
    in_valid = 4'b0000;
    tick();

`ifdef RR_ARB_MUX_LOCK_EN
    // burst lock on channel 0 while channel 1 keeps requesting
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 4'b0011;
    in_lock  = 4'b0001;
    set_data(0, 16'h00A1);
    #1;
    chk("lock.ready0", 32'(in_ready), 32'b0001);
    tick(); chk_out("lock.b1", 2'd0, 16'h00A1);
    in_valid = 4'b0010;
    #1;
    chk("lock.idle_ready", 32'(in_ready), 32'd0);
    tick();
    chk("lock.idle_valid", 32'(out_valid), 32'd0);
    in_valid = 4'b0011;
    set_data(0, 16'h00A2);
    tick(); chk_out("lock.b2", 2'd0, 16'h00A2);
    in_lock = 4'b0000;
    set_data(0, 16'h00A3);
    #1;
    chk("lock.ready2", 32'(in_ready), 32'b0001);
    tick(); chk_out("lock.b3", 2'd0, 16'h00A3);
    in_valid = 4'b0010;
    tick(); chk_out("lock.after", 2'd1, 16'h2222);
    in_valid = 4'b0000;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
